ibex_lsu_multi_outstanding: RTL

//  Load-store unit that keeps up to MaxOutstanding bus transactions in flight, for pipelined data memories.

---
 rtl/ibex_lsu_multi_outstanding.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_lsu_multi_outstanding.sv
// Load-store unit with up to MaxOutstanding pipelined bus transactions and in-order responses.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two word transactions; otherwise they are rejected.
module ibex_lsu_multi_outstanding #(
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_type_i,
    input  logic            lsu_sign_ext_i,
    input  logic [31:0]     lsu_addr_i,
    input  logic [31:0]     lsu_wdata_i,
    output logic            lsu_req_ready_o,
    output logic            lsu_resp_valid_o,
    output logic [31:0]     lsu_rdata_o,
    output logic            lsu_err_o,
    output logic            lsu_misaligned_err_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    output logic [31:0]     data_addr_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [31:0]     data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [31:0]     data_rdata_i,
    input  logic            data_err_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            busy_o
);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    typedef struct packed {
        logic [1:0] offset;
        logic [1:0] ltype;
        logic       sign;
        logic       we;
        logic       first_half;
    } entry_t;

    entry_t          fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [23:0]     hold_q, hold_d;
    logic            err_q, err_d;

    logic        push, pop;
    entry_t      push_entry, head;
    logic [1:0]  offset;
    logic        split, can_issue, fsm_busy;
    logic [3:0]  be_first, bus_be;
    logic [31:0] wdata_rot, addr_aligned, bus_addr;
    logic        data_req, req_ready;

    logic        head_split, resp_valid, resp_err;
    logic [63:0] combined;
    logic [31:0] shifted, extended, resp_rdata;

    // ---------------- request decode ----------------
    assign offset       = lsu_addr_i[1:0];
    assign addr_aligned = {lsu_addr_i[31:2], 2'b00};
    assign split        = ((lsu_type_i == 2'b00) && (offset != 2'b00)) ||
                          ((lsu_type_i == 2'b01) && (offset == 2'b11));
    // Only the registered count gates issue; a same-cycle pop never frees a slot early.
    assign can_issue    = (count_q < MaxCnt);

    always_comb begin
        be_first = 4'b0001 << offset;
        if (lsu_type_i == 2'b00) begin
            be_first = 4'b1111 << offset;
        end else if (lsu_type_i == 2'b01) begin
            be_first = 4'b0011 << offset;
        end
    end

    always_comb begin
        case (offset)
            2'b01:   wdata_rot = {lsu_wdata_i[23:0], lsu_wdata_i[31:24]};
            2'b10:   wdata_rot = {lsu_wdata_i[15:0], lsu_wdata_i[31:16]};
            2'b11:   wdata_rot = {lsu_wdata_i[7:0],  lsu_wdata_i[31:8]};
            default: wdata_rot = lsu_wdata_i;
        endcase
    end

`ifdef LSU_MISALIGNED_EN
    typedef enum logic {IDLE, SECOND} state_e;
    state_e     state_q, state_d;
    logic [3:0] be_second;

    always_comb begin
        be_second = 4'b0001;
        if (lsu_type_i == 2'b00) begin
            case (offset)
                2'b10:   be_second = 4'b0011;
                2'b11:   be_second = 4'b0111;
                default: be_second = 4'b0001;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        data_req   = 1'b0;
        req_ready  = 1'b0;
        push       = 1'b0;
        bus_addr   = addr_aligned;
        bus_be     = be_first;
        push_entry = {offset, lsu_type_i, lsu_sign_ext_i, lsu_we_i, 1'b0};
        case (state_q)
            IDLE: begin
                data_req = lsu_req_i & can_issue;
                if (data_req && data_gnt_i) begin
                    push                  = 1'b1;
                    push_entry.first_half = split;
                    if (split) begin
                        state_d = SECOND;
                    end else begin
                        req_ready = 1'b1;
                    end
                end
            end
            SECOND: begin
                data_req = can_issue;
                bus_addr = addr_aligned + 32'd4;
                bus_be   = be_second;
                if (data_req && data_gnt_i) begin
                    push      = 1'b1;
                    req_ready = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            data_req  = 1'b0;
            req_ready = 1'b0;
            push      = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign fsm_busy             = (state_q != IDLE);
    assign lsu_misaligned_err_o = 1'b0;
`else
    logic mis_accept, mis_pending_q;

    // Misaligned accesses wait for the bus to drain so their error response stays in order.
    always_comb begin
        data_req   = 1'b0;
        req_ready  = 1'b0;
        push       = 1'b0;
        mis_accept = 1'b0;
        bus_addr   = addr_aligned;
        bus_be     = be_first;
        push_entry = {offset, lsu_type_i, lsu_sign_ext_i, lsu_we_i, 1'b0};
        if (!rst_i && lsu_req_i) begin
            if (split) begin
                mis_accept = (count_q == '0);
                req_ready  = mis_accept;
            end else begin
                data_req = can_issue;
                if (can_issue && data_gnt_i) begin
                    push      = 1'b1;
                    req_ready = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mis_pending_q <= 1'b0;
        end else begin
            mis_pending_q <= mis_accept;
        end
    end

    assign fsm_busy             = 1'b0;
    assign lsu_misaligned_err_o = mis_pending_q;
`endif

    // ---------------- tracking FIFO ----------------
    assign head = fifo_q[rptr_q];
    assign pop  = data_rvalid_i & (count_q != '0) & ~rst_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= push_entry;
        end
    end

    // ---------------- response path ----------------
    assign head_split = ((head.ltype == 2'b00) && (head.offset != 2'b00)) ||
                        ((head.ltype == 2'b01) && (head.offset == 2'b11));

    always_comb begin
        // Second half of a split sits above the latched upper bytes of the first word.
        combined = head_split ? {data_rdata_i, hold_q, 8'h00} : {32'h0, data_rdata_i};
        shifted  = 32'(combined >> {head.offset, 3'b000});
        case (head.ltype)
            2'b00:   extended = shifted;
            2'b01:   extended = {{16{head.sign & shifted[15]}}, shifted[15:0]};
            default: extended = {{24{head.sign & shifted[7]}}, shifted[7:0]};
        endcase
        resp_valid = pop & ~head.first_half;
        resp_rdata = (resp_valid && !head.we) ? extended : 32'h0;
        resp_err   = resp_valid & (data_err_i | (head_split & err_q));
        hold_d     = hold_q;
        err_d      = err_q;
        if (pop && head.first_half) begin
            hold_d = data_rdata_i[31:8];
            err_d  = data_err_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // ---------------- outputs ----------------
`ifdef LSU_MISALIGNED_EN
    assign lsu_resp_valid_o = resp_valid;
    assign lsu_rdata_o      = resp_rdata;
    assign lsu_err_o        = resp_err;
`else
    assign lsu_resp_valid_o = resp_valid | mis_pending_q;
    assign lsu_rdata_o      = mis_pending_q ? 32'h0 : resp_rdata;
    assign lsu_err_o        = resp_err | mis_pending_q;
`endif

    assign lsu_req_ready_o = req_ready;
    assign data_req_o      = data_req;
    assign data_addr_o     = data_req ? bus_addr : 32'h0;
    assign data_be_o       = data_req ? bus_be : 4'h0;
    assign data_we_o       = data_req & lsu_we_i;
    assign data_wdata_o    = (data_req && lsu_we_i) ? wdata_rot : 32'h0;
    assign outstanding_o   = count_q;
    assign busy_o          = (count_q != '0) | fsm_busy;

`ifndef SYNTHESIS
    rvalid_without_entry: assert property (@(posedge clk_i) disable iff (rst_i)
        !(data_rvalid_i && (count_q == '0)));
`endif

endmodule
